mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised up/down modulo counter with synchronous clear, parallel load, clock-enable prescaler, selectable wrap/saturate mode and terminal-count/overflow reporting. Successor to the fixed up-counter. Used as the general event/timebase counter in datapath and control blocks. Every counting behaviour is fixed at elaboration by parameters. Direction changes at run time through one port.

## Interface
- `WIDTH`, 32: counter width in bits; legal range 2..32.
- `MAX_VAL`, 15: top count. Counting range is 0..MAX_VAL inclusive. Must be < 2^WIDTH.
- `SATURATE`, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.
- `PRESCALE`, 1: number of enabled cycles per count step. 1 means a step on every enabled cycle. Legal range 1..65536.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high. The only clock is `clk`.
- `clr` in 1: synchronous clear.
- `en` in 1: count enable; feeds the prescaler.
- `ld` in 1: synchronous parallel load.
- `ld_val` in WIDTH: load value.
- `dir` in 1: 1 = count up, 0 = count down.
- `cnt` out WIDTH: current count, registered.
- `tc` out 1: terminal-count pulse, registered.
- `ovf` out 1: sticky boundary-event flag, registered.

## Operation
- Reset: `rst` = 1 forces `cnt` = 0, `tc` = 0, `ovf` = 0 and prescaler = 0, immediately and independent of `clk`. Reset taken mid-count abandons all state.
- Per-edge priority: `clr` > `ld` > step > hold.
- `clr`: sets `cnt` = 0, `ovf` = 0, `tc` = 0 and prescaler = 0. Overrides `ld` and `en` in the same cycle.
- `ld`: sets `cnt` = min(`ld_val`, MAX_VAL), clamping any out-of-range value. Also sets prescaler = 0 and `tc` = 0; `ovf` is unchanged.
- Prescaler:
  - Counts 0..PRESCALE-1 on cycles with `en` = 1 and no `clr`/`ld`.
  - A step fires on an enabled cycle with prescaler = PRESCALE-1; the prescaler then returns to 0.
  - With `en` = 0 the prescaler holds.
  - With PRESCALE = 1, every enabled cycle is a step.
- Step, up (`dir` = 1):
  - `cnt` < MAX_VAL: `cnt` + 1.
  - `cnt` = MAX_VAL, wrap mode: `cnt` becomes 0, `tc` = 1, `ovf` set.
  - `cnt` = MAX_VAL, saturate mode: `cnt` holds, `tc` = 1, `ovf` set.
- Step, down (`dir` = 0):
  - `cnt` > 0: `cnt` - 1.
  - `cnt` = 0, wrap mode: `cnt` becomes MAX_VAL, `tc` = 1, `ovf` set.
  - `cnt` = 0, saturate mode: `cnt` holds, `tc` = 1, `ovf` set.
- `tc` is 0 on every cycle that is not a boundary step. In saturate mode, repeated steps at the boundary assert `tc` on each such step.
- `dir` is sampled only on step cycles and may change on any cycle.
- Arithmetic:
  - Compute the next value WIDTH+1 bits wide; only boundary comparison selects wrap.
  - No reliance on native 2^WIDTH roll-over: MAX_VAL = 2^WIDTH-1 behaves identically to any other modulus.

## Timing
- Latency: `cnt`, `tc` and `ovf` change on the `clk` edge that samples the causing input, and are visible on the following cycle. There are no combinational paths from input to output.
- `tc` is high for exactly one cycle per boundary step, aligned with the cycle in which `cnt` shows the post-step value.
- Step cadence with `en` held high: one step every PRESCALE cycles. The first step occurs PRESCALE enabled cycles after reset, clear or load.
- `en` low for N cycles delays the next step by exactly N cycles.
- Reset release: the first edge at which `rst` is sampled low may already count.

## Structure
- Package `counter_pkg` holds:
  - Constants `CNT_WRAP` = 0, `CNT_SAT` = 1.
  - Constants `DIR_DOWN` = 0, `DIR_UP` = 1.
  - Function `clog2` for the prescaler width.
- Sub-module `cnt_prescaler` (params `PRESCALE`; ports `clk`, `rst`, `sync_clr`, `en`, `tick`):
  - Output `tick` is combinational.
  - With PRESCALE = 1 it degenerates to `tick` = `en`.
- Top level: one next-state block for `cnt`/`tc`/`ovf`, plus parameter legality checks at elaboration.

## Test plan
- Defaults (WIDTH 32, MAX 15, wrap, PRESCALE 1), `en` = 1, `dir` = 1 after reset → `cnt` 0,1,…,15,0; `tc` high only in the cycle `cnt` = 0 after 15; `ovf` = 1 from then on.
- `dir` = 0 from reset, wrap → `cnt` 0→15→14; `tc` pulses on the 0→15 step; then `clr` → `cnt` = 0, `ovf` = 0 next cycle.
- SATURATE = 1, MAX 9, up for 12 steps → `cnt` sticks at 9; `tc` pulses on each of steps 10, 11 and 12; `ovf` = 1.
- PRESCALE = 4, `en` = 1 with a 3-cycle `en` = 0 gap → `cnt` increments every 4 enabled cycles; the gap delays the next increment by exactly 3 cycles.
- `ld` = 1 with `ld_val` = 100 (MAX 15) → `cnt` = 15. Simultaneous `clr` and `ld` → `cnt` = 0. `ld` together with a boundary step → loaded value, `tc` = 0.
- `rst` asserted mid-count, between edges → `cnt`, `tc` and `ovf` go to 0 before the next edge; counting restarts from 0 on the first edge after release.

Source files
------------

// File: rtl/mod_updown_counter_pkg.sv
// Shared constants, the per-edge operation type and a constant log2 helper
// for the up/down modulo counter.
package counter_pkg;

  // Boundary behaviour selected by the SATURATE parameter.
  localparam int unsigned CNT_WRAP = 0;
  localparam int unsigned CNT_SAT  = 1;

  // Encoding of the dir input.
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Operation applied on an edge, already resolved by priority.
  typedef enum logic [1:0] {
    OpHold,
    OpStep,
    OpLoad,
    OpClear
  } cnt_op_e;

  // Ceiling log2; returns 0 for 1. Used to size the prescaler register.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (longint unsigned p = 1; p < longint'(value); p = p << 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of the up/down counter. The master side drives the
// controls and observes the count; the slave side is the counter itself.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             clr;
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             dir;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             ovf;

  modport master (
    output clr, en, ld, ld_val, dir,
    input  cnt, tc, ovf
  );

  modport slave (
    input  clr, en, ld, ld_val, dir,
    output cnt, tc, ovf
  );

endinterface

// File: rtl/mod_updown_counter_prescaler.sv
// Clock-enable prescaler: emits a combinational tick on every PRESCALE-th
// enabled cycle. With PRESCALE = 1 the tick is simply the enable.
module cnt_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_clr,
  input  logic en,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, rst, sync_clr};
    assign tick      = en;
  end else begin : g_div
    localparam int unsigned PW = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;

    assign tick = en && (pre_q == LAST);

    // Phase counter: cleared by clear/load, holds while disabled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pre_q <= '0;
      end else if (sync_clr) begin
        pre_q <= '0;
      end else if (en) begin
        pre_q <= tick ? '0 : pre_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with synchronous clear, clamped
// parallel load, prescaled enable, wrap/saturate boundaries and tc/ovf flags.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_VAL  = 15,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned PRESCALE = 1
) (
  input logic                  clk,
  input logic                  rst,
  mod_updown_counter_if.slave  bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 2..32");
  end
  if ((64'(MAX_VAL) >> WIDTH) != 64'd0) begin : g_bad_max
    $error("mod_updown_counter: MAX_VAL must be below 2**WIDTH");
  end
  if (SATURATE > 1) begin : g_bad_sat
    $error("mod_updown_counter: SATURATE must be 0 or 1");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_pre
    $error("mod_updown_counter: PRESCALE must be in 1..65536");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX_W};
  localparam bit               SAT   = (SATURATE == CNT_SAT);

  logic             tick;
  logic             pre_clr;
  cnt_op_e          op;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   nxt_x;
  logic [WIDTH:0]   ld_x;

  // Load also restarts the step phase, so the next step is a full period away.
  assign pre_clr = bus.clr | bus.ld;

  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .sync_clr (pre_clr),
    .en       (bus.en),
    .tick     (tick)
  );

  // Resolve clear > load > step > hold.
  always_comb begin
    op = OpHold;
    if (bus.clr) begin
      op = OpClear;
    end else if (bus.ld) begin
      op = OpLoad;
    end else if (tick) begin
      op = OpStep;
    end
  end

  // Next count and flags; arithmetic is one bit wider so the boundary test,
  // not native roll-over, decides wrapping.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    cnt_x = {1'b0, cnt_q};
    nxt_x = cnt_x;
    ld_x  = {1'b0, bus.ld_val};
    unique case (op)
      OpClear: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      OpLoad: begin
        cnt_d = (ld_x > MAX_X) ? MAX_W : bus.ld_val;
      end
      OpStep: begin
        if (bus.dir == DIR_UP) begin
          if (cnt_x >= MAX_X) begin
            cnt_d = SAT ? cnt_q : '0;
            tc_d  = 1'b1;
            ovf_d = 1'b1;
          end else begin
            nxt_x = cnt_x + (WIDTH+1)'(1);
            cnt_d = nxt_x[WIDTH-1:0];
          end
        end else begin
          if (cnt_x == '0) begin
            cnt_d = SAT ? cnt_q : MAX_W;
            tc_d  = 1'b1;
            ovf_d = 1'b1;
          end else begin
            nxt_x = cnt_x - (WIDTH+1)'(1);
            cnt_d = nxt_x[WIDTH-1:0];
          end
        end
      end
      OpHold: begin
      end
    endcase
  end

  // Output registers; reset abandons everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: four configurations driven from one
// linear sequence, outputs sampled on the falling edge.
module tb_mod_updown_counter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(32)) bus_def  ();
  mod_updown_counter_if #(.WIDTH(4))  bus_full ();
  mod_updown_counter_if #(.WIDTH(8))  bus_sat  ();
  mod_updown_counter_if #(.WIDTH(32)) bus_pre  ();

  // Defaults: 32 bits, MAX 15, wrap, no prescale.
  mod_updown_counter u_def (
    .clk (clk),
    .rst (rst),
    .bus (bus_def)
  );

  // MAX equal to 2**WIDTH-1 must behave like the default modulus.
  mod_updown_counter #(
    .WIDTH    (4),
    .MAX_VAL  (15),
    .SATURATE (0),
    .PRESCALE (1)
  ) u_full (
    .clk (clk),
    .rst (rst),
    .bus (bus_full)
  );

  mod_updown_counter #(
    .WIDTH    (8),
    .MAX_VAL  (9),
    .SATURATE (1),
    .PRESCALE (1)
  ) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  mod_updown_counter #(
    .WIDTH    (32),
    .MAX_VAL  (15),
    .SATURATE (0),
    .PRESCALE (4)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .bus (bus_pre)
  );

  assign bus_full.clr    = bus_def.clr;
  assign bus_full.en     = bus_def.en;
  assign bus_full.dir    = bus_def.dir;
  assign bus_full.ld     = 1'b0;
  assign bus_full.ld_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus_def.clr = 1'b0; bus_def.en = 1'b0; bus_def.ld = 1'b0;
    bus_def.ld_val = '0; bus_def.dir = 1'b1;
    bus_sat.clr = 1'b0; bus_sat.en = 1'b0; bus_sat.ld = 1'b0;
    bus_sat.ld_val = '0; bus_sat.dir = 1'b1;
    bus_pre.clr = 1'b0; bus_pre.en = 1'b0; bus_pre.ld = 1'b0;
    bus_pre.ld_val = '0; bus_pre.dir = 1'b1;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_def_cnt", bus_def.cnt, 0);
    chk("rst_def_tc", 32'(bus_def.tc), 0);
    chk("rst_def_ovf", 32'(bus_def.ovf), 0);
    chk("rst_sat_cnt", 32'(bus_sat.cnt), 0);
    chk("rst_pre_cnt", bus_pre.cnt, 0);

    // Up count from reset release; the first edge already counts.
    rst = 1'b0;
    bus_def.en = 1'b1; bus_def.dir = 1'b1;
    bus_sat.en = 1'b1; bus_sat.dir = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk($sformatf("up_def_cnt_%0d", i), bus_def.cnt, 32'(i % 16));
      chk($sformatf("up_def_tc_%0d", i), 32'(bus_def.tc), 32'(i == 16));
      chk($sformatf("up_def_ovf_%0d", i), 32'(bus_def.ovf), 32'(i >= 16));
      chk($sformatf("up_full_cnt_%0d", i), 32'(bus_full.cnt), 32'(i % 16));
      chk($sformatf("up_full_tc_%0d", i), 32'(bus_full.tc), 32'(i == 16));
      chk($sformatf("sat_cnt_%0d", i), 32'(bus_sat.cnt), 32'((i < 9) ? i : 9));
      chk($sformatf("sat_tc_%0d", i), 32'(bus_sat.tc), 32'(i >= 10 && i <= 12));
      chk($sformatf("sat_ovf_%0d", i), 32'(bus_sat.ovf), 32'(i >= 10));
      if (i == 12) bus_sat.en = 1'b0;
    end
    chk("pre_idle_cnt", bus_pre.cnt, 0);

    // Clear, then count down through the zero boundary.
    bus_def.clr = 1'b1;
    step();
    chk("clr_cnt", bus_def.cnt, 0);
    chk("clr_ovf", 32'(bus_def.ovf), 0);
    bus_def.clr = 1'b0; bus_def.dir = 1'b0;
    step();
    chk("dn_cnt_wrap", bus_def.cnt, 15);
    chk("dn_tc_wrap", 32'(bus_def.tc), 1);
    chk("dn_ovf_wrap", 32'(bus_def.ovf), 1);
    chk("dn_full_cnt_wrap", 32'(bus_full.cnt), 15);
    step();
    chk("dn_cnt_14", bus_def.cnt, 14);
    chk("dn_tc_14", 32'(bus_def.tc), 0);
    chk("dn_full_cnt_14", 32'(bus_full.cnt), 14);
    bus_def.clr = 1'b1;
    step();
    chk("clr2_cnt", bus_def.cnt, 0);
    chk("clr2_ovf", 32'(bus_def.ovf), 0);

    // Loads: clamp, clear priority, load over a boundary step.
    bus_def.clr = 1'b0; bus_def.dir = 1'b1; bus_def.en = 1'b1;
    bus_def.ld = 1'b1; bus_def.ld_val = 32'd100;
    step();
    chk("ld_clamp_cnt", bus_def.cnt, 15);
    chk("ld_clamp_tc", 32'(bus_def.tc), 0);
    bus_def.clr = 1'b1; bus_def.ld_val = 32'd5;
    step();
    chk("clr_over_ld_cnt", bus_def.cnt, 0);
    bus_def.clr = 1'b0; bus_def.en = 1'b0; bus_def.ld_val = 32'd15;
    step();
    chk("ld15_cnt", bus_def.cnt, 15);
    bus_def.ld = 1'b0; bus_def.en = 1'b1;
    step();
    chk("wrap_after_ld_cnt", bus_def.cnt, 0);
    chk("wrap_after_ld_tc", 32'(bus_def.tc), 1);
    chk("wrap_after_ld_ovf", 32'(bus_def.ovf), 1);
    bus_def.ld = 1'b1; bus_def.en = 1'b0; bus_def.ld_val = 32'd15;
    step();
    bus_def.en = 1'b1; bus_def.ld_val = 32'd3;
    step();
    chk("ld_vs_step_cnt", bus_def.cnt, 3);
    chk("ld_vs_step_tc", 32'(bus_def.tc), 0);
    chk("ld_keeps_ovf", 32'(bus_def.ovf), 1);
    bus_def.ld = 1'b0;
    step();
    chk("after_ld_cnt", bus_def.cnt, 4);
    bus_def.en = 1'b0;

    // Prescaler: step every 4 enabled cycles; a 3-cycle gap delays by 3.
    bus_pre.en = 1'b1; bus_pre.dir = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("pre_cnt_%0d", k), bus_pre.cnt, (k == 4) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 2; k++) begin
      step();
      chk($sformatf("pre_run_%0d", k), bus_pre.cnt, 1);
    end
    bus_pre.en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("pre_gap_%0d", k), bus_pre.cnt, 1);
    end
    bus_pre.en = 1'b1;
    step();
    chk("pre_resume_1", bus_pre.cnt, 1);
    step();
    chk("pre_resume_2", bus_pre.cnt, 2);
    chk("pre_tc", 32'(bus_pre.tc), 0);

    // Asynchronous reset between edges, then restart from 0.
    bus_def.en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", bus_def.cnt, 0);
    chk("async_rst_ovf", 32'(bus_def.ovf), 0);
    chk("async_rst_tc", 32'(bus_def.tc), 0);
    chk("async_rst_pre", bus_pre.cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_cnt", bus_def.cnt, 1);
    chk("post_rst_ovf", 32'(bus_def.ovf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
